// File: rtl/vector_alu_seq_pkg.sv
// Shared types for the single-lane vector ALU: opcode and control-state encodings.
package vector_alu_pkg;

  localparam int op_width_gp = 3;

  typedef enum logic [op_width_gp-1:0] {
    eAdd = 3'd0,
    eSub = 3'd1,
    eMul = 3'd2,
    eMin = 3'd3,
    eMax = 3'd4,
    eAnd = 3'd5,
    eOr  = 3'd6,
    eXor = 3'd7
  } eOp;

  // eOp already owns the name eMul, so the multiply control state is eMulRun.
  typedef enum logic {
    eIdle   = 1'b0,
    eMulRun = 1'b1
  } eState;

endpackage

// File: rtl/vector_alu_seq_if.sv
// Issue (valid/ready) and result (valid/yumi) bundle between a register-file read stage and one ALU lane.
interface vector_alu_seq_if
  import vector_alu_pkg::*;
#(
  parameter int vdw_p = 32
) ();

  logic             v_i;
  logic             ready_o;
  logic [vdw_p-1:0] a_i;
  logic [vdw_p-1:0] b_i;
  eOp               op_i;
  logic             sat_i;
  logic             v_o;
  logic             yumi_i;
  logic [vdw_p-1:0] result_o;
  logic             flag_overflow_o;
  logic             flag_zero_o;
  logic             flag_negative_o;

  modport master (
    output v_i, a_i, b_i, op_i, sat_i, yumi_i,
    input  ready_o, v_o, result_o, flag_overflow_o, flag_zero_o, flag_negative_o
  );

  modport slave (
    input  v_i, a_i, b_i, op_i, sat_i, yumi_i,
    output ready_o, v_o, result_o, flag_overflow_o, flag_zero_o, flag_negative_o
  );

endinterface

// File: rtl/vector_alu_seq_mul_iter.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per cycle through a single adder.
module vector_alu_mul_iter
  import vector_alu_pkg::*;
#(
  parameter  int vdw_p        = 32,
  localparam int cnt_width_lp = $clog2(vdw_p)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic               step_i,
  input  logic [vdw_p-1:0]   a_i,
  input  logic [vdw_p-1:0]   b_i,
  output logic               done_o,
  output logic [2*vdw_p-1:0] product_o
);

  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(vdw_p - 1);

  logic [2*vdw_p-1:0]  mcand_q;
  logic [vdw_p-1:0]    mplier_q;
  logic [2*vdw_p-1:0]  acc_q, acc_d;
  logic [cnt_width_lp-1:0] cnt_q;

  // The multiplicand is pre-shifted each step, so the only wide adder is acc + partial.
  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = step_i && (cnt_q == last_cnt_lp);
  assign product_o = acc_d;

  // NOTE: accumulator and counter are plain flops, not a memory, so they take the async
  // reset; an aborted multiply therefore leaves nothing behind for the next start.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
    if (!reset_n_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      mcand_q  <= {{vdw_p{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_d;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/vector_alu_seq.sv
// One vector ALU lane: single-cycle add/sub/min/max/logic, iterative multiply, registered result with yumi hold.
module vector_alu_seq
  import vector_alu_pkg::*;
#(
  parameter int vdw_p = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  vector_alu_seq_if.slave  alu_io
);

  eState            state_q, state_d;
  logic             v_q, v_d;
  logic [vdw_p-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, neg_q;
  logic             sat_q;
  logic             load;
  logic             ready, accept;

  logic               mul_start, mul_step, mul_done;
  logic [2*vdw_p-1:0] product;
  logic [vdw_p-1:0]   mul_hi, mul_lo;
  logic               mul_ovf;

  logic [vdw_p:0]   sum_w, diff_w;
  logic             b_lt_a, b_gt_a;
  logic [vdw_p-1:0] alu_res;
  logic             alu_ovf;

  vector_alu_mul_iter #(.vdw_p(vdw_p)) u_mul (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .start_i   (mul_start),
    .step_i    (mul_step),
    .a_i       (alu_io.a_i),
    .b_i       (alu_io.b_i),
    .done_o    (mul_done),
    .product_o (product)
  );

  assign mul_hi  = product[2*vdw_p-1:vdw_p];
  assign mul_lo  = product[vdw_p-1:0];
  assign mul_ovf = |mul_hi;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sum_w   = {1'b0, alu_io.a_i} + {1'b0, alu_io.b_i};
    diff_w  = {1'b0, alu_io.a_i} + {1'b0, ~alu_io.b_i} + {{vdw_p{1'b0}}, 1'b1};
    b_lt_a  = $signed(alu_io.b_i) < $signed(alu_io.a_i);
    b_gt_a  = $signed(alu_io.b_i) > $signed(alu_io.a_i);
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_io.op_i)
      eAdd: begin
        alu_ovf = sum_w[vdw_p];
        alu_res = (alu_io.sat_i && alu_ovf) ? '1 : sum_w[vdw_p-1:0];
      end
      eSub: begin
        alu_ovf = ~diff_w[vdw_p];
        alu_res = (alu_io.sat_i && alu_ovf) ? '0 : diff_w[vdw_p-1:0];
      end
      // Ties fall through to operand A.
      eMin:    alu_res = b_lt_a ? alu_io.b_i : alu_io.a_i;
      eMax:    alu_res = b_gt_a ? alu_io.b_i : alu_io.a_i;
      eAnd:    alu_res = alu_io.a_i & alu_io.b_i;
      eOr:     alu_res = alu_io.a_i | alu_io.b_i;
      eXor:    alu_res = alu_io.a_i ^ alu_io.b_i;
      default: alu_res = '0;
    endcase
  end

  assign ready  = (state_q == eIdle) && (!v_q || alu_io.yumi_i);
  assign accept = alu_io.v_i && ready;

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    load      = 1'b0;
    result_d  = result_q;
    ovf_d     = ovf_q;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    case (state_q)
      eIdle: begin
        if (alu_io.yumi_i) v_d = 1'b0;
        if (accept) begin
          if (alu_io.op_i == eMul) begin
            mul_start = 1'b1;
            state_d   = eMulRun;
          end else begin
            v_d      = 1'b1;
            load     = 1'b1;
            result_d = alu_res;
            ovf_d    = alu_ovf;
          end
        end
      end
      eMulRun: begin
        mul_step = 1'b1;
        if (mul_done) begin
          state_d  = eIdle;
          v_d      = 1'b1;
          load     = 1'b1;
          result_d = (sat_q && mul_ovf) ? '1 : mul_lo;
          ovf_d    = mul_ovf;
        end
      end
      default: state_d = eIdle;
    endcase
  end

  // Zero/negative are captured only on load so they track the held result, not the live datapath.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= eIdle;
      v_q      <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      if (mul_start) sat_q <= alu_io.sat_i;
      if (load) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        zero_q   <= (result_d == '0);
        neg_q    <= result_d[vdw_p-1];
      end
    end
  end

  assign alu_io.ready_o         = ready;
  assign alu_io.v_o             = v_q;
  assign alu_io.result_o        = result_q;
  assign alu_io.flag_overflow_o = ovf_q;
  assign alu_io.flag_zero_o     = zero_q;
  assign alu_io.flag_negative_o = neg_q;

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    alu_io.yumi_i |-> v_q);

  a_op_known: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    alu_io.v_i |-> !$isunknown(alu_io.op_i));

endmodule

// File: tb/tb_vector_alu_seq.sv
// Directed and random stimulus for one 8-bit ALU lane, checked against an arithmetic reference model.
module tb_vector_alu_seq;
  import vector_alu_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  logic yumi_en;
  int   errors;
  int   checks;

  vector_alu_seq_if #(.vdw_p(W)) ifc ();

  vector_alu_seq #(.vdw_p(W)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .alu_io    (ifc)
  );

  // Consumer only takes a result that is actually presented.
  assign ifc.yumi_i = yumi_en & ifc.v_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned/signed readings of the operands.
  function automatic void model(input eOp op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sat, output logic [W-1:0] res, output logic ovf);
    int ua, ub, sa, sb, full;
    ua   = int'(a);
    ub   = int'(b);
    sa   = (ua >= 128) ? ua - 256 : ua;
    sb   = (ub >= 128) ? ub - 256 : ub;
    ovf  = 1'b0;
    full = 0;
    case (op)
      eAdd: begin full = ua + ub; ovf = (full > 255); if (ovf && sat) full = 255; end
      eSub: begin full = ua - ub; ovf = (full < 0);   if (ovf && sat) full = 0;   end
      eMul: begin full = ua * ub; ovf = (full > 255); if (ovf && sat) full = 255; end
      eMin: full = (sb < sa) ? ub : ua;
      eMax: full = (sb > sa) ? ub : ua;
      eAnd: full = ua & ub;
      eOr:  full = ua | ub;
      eXor: full = ua ^ ub;
      default: full = 0;
    endcase
    res = W'(full);
  endfunction

  task automatic drive(input eOp op, input logic [W-1:0] a, input logic [W-1:0] b, input logic sat);
    ifc.v_i   = 1'b1;
    ifc.op_i  = op;
    ifc.a_i   = a;
    ifc.b_i   = b;
    ifc.sat_i = sat;
  endtask

  task automatic check_result(input string tag, input eOp op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic sat);
    logic [W-1:0] er;
    logic         eo;
    model(op, a, b, sat, er, eo);
    check({tag, "_v"},   ifc.v_o, 1);
    check({tag, "_res"}, ifc.result_o, er);
    check({tag, "_ovf"}, ifc.flag_overflow_o, eo);
    check({tag, "_zero"}, ifc.flag_zero_o, (er == '0));
    check({tag, "_neg"}, ifc.flag_negative_o, er[W-1]);
  endtask

  // Issue one op, measure edges from accept to v_o, then check the result.
  task automatic run_op(input eOp op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sat, input string tag);
    int   n;
    logic busy_rdy;
    @(negedge clk);
    check({tag, "_rdy"}, ifc.ready_o, 1);
    drive(op, a, b, sat);
    @(posedge clk);
    #1;
    ifc.v_i  = 1'b0;
    n        = 0;
    busy_rdy = 1'b0;
    while (!ifc.v_o && n < 40) begin
      if (ifc.ready_o) busy_rdy = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, (op == eMul) ? W : 0);
    if (op == eMul) check({tag, "_busy_rdy"}, busy_rdy, 0);
    check_result(tag, op, a, b, sat);
  endtask

  initial begin
    eOp           sop[6];
    logic [W-1:0] sa[6];
    logic [W-1:0] sb[6];
    logic         ss[6];
    logic         seen_v;

    errors  = 0;
    checks  = 0;
    yumi_en = 1'b1;
    rst_n   = 1'b0;
    drive(eAdd, '0, '0, 1'b0);
    ifc.v_i = 1'b0;

    // Reset holds everything at zero even with traffic presented.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(eOp'(3'($urandom_range(0, 7))), W'($urandom), W'($urandom), 1'($urandom));
      #1;
      check("rst_outs", {ifc.v_o, ifc.result_o, ifc.flag_overflow_o,
                         ifc.flag_zero_o, ifc.flag_negative_o}, '0);
    end
    @(negedge clk);
    ifc.v_i = 1'b0;
    rst_n   = 1'b1;
    #1;
    check("rst_ready", ifc.ready_o, 1);

    run_op(eAdd, 8'hF0, 8'h20, 1'b0, "add_wrap");
    run_op(eAdd, 8'hF0, 8'h20, 1'b1, "add_sat");
    run_op(eSub, 8'h05, 8'h07, 1'b1, "sub_sat");
    run_op(eSub, 8'h07, 8'h05, 1'b0, "sub_plain");
    run_op(eMul, 8'h0F, 8'h11, 1'b0, "mul_ff");
    run_op(eMul, 8'h10, 8'h10, 1'b1, "mul_sat");
    run_op(eMin, 8'h80, 8'h7F, 1'b0, "min");
    run_op(eMax, 8'h80, 8'h7F, 1'b0, "max");
    run_op(eMin, 8'h33, 8'h33, 1'b0, "min_tie");

    // Back-to-back stream with yumi always available: one result per cycle.
    for (int i = 0; i < 6; i++) begin
      sop[i] = eOp'(3'($urandom_range(0, 7)));
      if (sop[i] == eMul) sop[i] = eXor;
      sa[i] = W'($urandom);
      sb[i] = W'($urandom);
      ss[i] = 1'($urandom);
    end
    @(negedge clk);
    drive(sop[0], sa[0], sb[0], ss[0]);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_result("stream", sop[i], sa[i], sb[i], ss[i]);
      check("stream_rdy", ifc.ready_o, 1);
      if (i < 5) drive(sop[i+1], sa[i+1], sb[i+1], ss[i+1]);
      else       ifc.v_i = 1'b0;
    end

    // Backpressure: result held while the next op waits, then accepted on the yumi cycle.
    @(posedge clk);
    #1;
    yumi_en = 1'b0;
    drive(eXor, 8'hAA, 8'hFF, 1'b0);
    @(posedge clk);
    #1;
    drive(eAdd, 8'h01, 8'h02, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check_result("hold", eXor, 8'hAA, 8'hFF, 1'b0);
      check("hold_rdy", ifc.ready_o, 0);
      @(posedge clk);
      #1;
    end
    yumi_en = 1'b1;
    #1;
    check("yumi_rdy", ifc.ready_o, 1);
    @(posedge clk);
    #1;
    ifc.v_i = 1'b0;
    check_result("after_hold", eAdd, 8'h01, 8'h02, 1'b0);

    // Reset in the third cycle of a multiply: the op vanishes.
    @(negedge clk);
    drive(eMul, 8'h0B, 8'h0D, 1'b0);
    @(posedge clk);
    #1;
    ifc.v_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_v", ifc.v_o, 0);
    check("midrst_res", ifc.result_o, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    seen_v = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (ifc.v_o) seen_v = 1'b1;
    end
    check("midrst_no_v", seen_v, 0);
    check("midrst_idle", ifc.ready_o, 1);
    run_op(eMul, 8'h0B, 8'h0D, 1'b0, "mul_recover");

    // Random mix including multiplies.
    for (int i = 0; i < 24; i++) begin
      run_op(eOp'(3'($urandom_range(0, 7))), W'($urandom), W'($urandom), 1'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
